// File: rtl/button_pkg.sv
// Shared definitions for the push-button debouncer.
//   btn_state_e          : per-channel FSM state encoding
//   DEF_N_BUTTONS        : default channel count
//   DEF_DEBOUNCE_CYCLES  : default stability window (10 ms at 50 MHz)
//   DEF_HOLD_CYCLES      : default long-press window (1 s at 50 MHz)
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } btn_state_e;

    localparam int DEF_N_BUTTONS       = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 50000000;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, hold counter.
//   i_clock         : system clock, rising edge
//   i_nreset        : asynchronous active-low reset
//   i_button_n      : raw active-low button, asynchronous to i_clock
//   o_pressed       : debounced level, 1 = held down
//   o_press_pulse   : one-cycle strobe on accepted press
//   o_release_pulse : one-cycle strobe on accepted release
//   o_hold_pulse    : one-cycle strobe once a press has lasted HOLD_CYCLES
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic i_clock,
    input  logic i_nreset,
    input  logic i_button_n,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_hold_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_e       r_state;
    logic [DB_W-1:0]  r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic             r_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_hold_pulse;

    // Synchronizer idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_button_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state         <= IDLE;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_hold_pulse    <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_hold_pulse    <= 1'b0;

            // Hold timer runs while the button is logically down, including
            // the release-debounce window; it saturates so only one hold
            // strobe is produced per press.
            if ((r_state == PRESSED || r_state == DB_RELEASE) &&
                r_hold_cnt != HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
                if (r_hold_cnt == HOLD_LAST)
                    r_hold_pulse <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
                    if (!r_sync2) begin
                        r_state  <= DB_PRESS;
                        r_db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (r_sync2) begin
                        r_state <= IDLE;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state       <= PRESSED;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (r_sync2) begin
                        r_state  <= DB_RELEASE;
                        r_db_cnt <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (!r_sync2) begin
                        r_state <= PRESSED;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state         <= IDLE;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_hold_pulse    = r_hold_pulse;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer; one independent button_channel per bit.
//   i_clock         : system clock, rising edge
//   i_nreset        : asynchronous active-low reset
//   i_button_n      : raw active-low buttons [N_BUTTONS]
//   o_pressed       : debounced levels [N_BUTTONS]
//   o_press_pulse   : press strobes [N_BUTTONS]
//   o_release_pulse : release strobes [N_BUTTONS]
//   o_hold_pulse    : long-press strobes [N_BUTTONS]
module button_debounce
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = DEF_N_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic                 i_clock,
    input  logic                 i_nreset,
    input  logic [N_BUTTONS-1:0] i_button_n,
    output logic [N_BUTTONS-1:0] o_pressed,
    output logic [N_BUTTONS-1:0] o_press_pulse,
    output logic [N_BUTTONS-1:0] o_release_pulse,
    output logic [N_BUTTONS-1:0] o_hold_pulse
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_chan (
            .i_clock         (i_clock),
            .i_nreset        (i_nreset),
            .i_button_n      (i_button_n[g]),
            .o_pressed       (o_pressed[g]),
            .o_press_pulse   (o_press_pulse[g]),
            .o_release_pulse (o_release_pulse[g]),
            .o_hold_pulse    (o_hold_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] btn = 3'b111;
    logic [2:0] pressed, pp, rp, hp;

    always #10 clk = ~clk;

    button_debounce #(
        .N_BUTTONS       (3),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16)
    ) dut (
        .i_clock         (clk),
        .i_nreset        (nreset),
        .i_button_n      (btn),
        .o_pressed       (pressed),
        .o_press_pulse   (pp),
        .o_release_pulse (rp),
        .o_hold_pulse    (hp)
    );

    typedef struct {
        int         c;
        logic [2:0] pp;
        logic [2:0] rp;
        logic [2:0] hp;
        logic [2:0] pr;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errs = 0;
    int   m;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard insert, kept ordered by cycle.
    task automatic push(input int c, input logic [2:0] epp, input logic [2:0] erp,
                        input logic [2:0] ehp, input logic [2:0] epr, input string nm);
        exp_t x;
        int   i = 0;
        x.c = c; x.pp = epp; x.rp = erp; x.hp = ehp; x.pr = epr; x.nm = nm;
        while (i < q.size() && q[i].c <= c) i++;
        q.insert(i, x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares at expected cycles, flags any pulse nobody expected.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            checks++;
            errs++;
            $display("FAIL %s: expected event at cycle %0d not compared (now %0d)", e.nm, e.c, cyc);
        end else if (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            checks++;
            if ({pp, rp, hp, pressed} !== {e.pp, e.rp, e.hp, e.pr}) begin
                errs++;
                $display("FAIL %s @%0d: got pp=%b rp=%b hp=%b pr=%b, want pp=%b rp=%b hp=%b pr=%b",
                         e.nm, cyc, pp, rp, hp, pressed, e.pp, e.rp, e.hp, e.pr);
            end
        end else if ((pp | rp | hp) != 3'b000) begin
            checks++;
            errs++;
            $display("FAIL unexpected_pulse @%0d: got pp=%b rp=%b hp=%b, want none", cyc, pp, rp, hp);
        end
    end

    initial begin
        // Reset state
        push(2, 3'b000, 3'b000, 3'b000, 3'b000, "reset_state");
        tick(3);
        nreset = 1'b1;
        tick(5);

        // Clean press of button 0, hold, clean release
        tick(1); m = cyc; btn[0] = 1'b0;
        push(m + 8,  3'b001, 3'b000, 3'b000, 3'b001, "t1_press");
        push(m + 12, 3'b000, 3'b000, 3'b000, 3'b001, "t1_level");
        push(m + 24, 3'b000, 3'b000, 3'b001, 3'b001, "t1_hold");
        tick(30); btn[0] = 1'b1;
        push(m + 38, 3'b000, 3'b001, 3'b000, 3'b000, "t1_release");
        push(m + 42, 3'b000, 3'b000, 3'b000, 3'b000, "t1_idle");
        tick(20);

        // Bouncing press on button 1
        tick(1); m = cyc; btn[1] = 1'b0;
        tick(2); btn[1] = 1'b1;
        tick(1); btn[1] = 1'b0;
        push(m + 11, 3'b010, 3'b000, 3'b000, 3'b010, "t2_bounce_press");
        tick(10); btn[1] = 1'b1;
        push(m + 21, 3'b000, 3'b010, 3'b000, 3'b000, "t2_release");
        tick(20);

        // Release glitch on button 2; hold counter must be retained
        tick(1); m = cyc; btn[2] = 1'b0;
        push(m + 8,  3'b100, 3'b000, 3'b000, 3'b100, "t3_press");
        tick(12); btn[2] = 1'b1;
        tick(2);  btn[2] = 1'b0;
        push(m + 16, 3'b000, 3'b000, 3'b000, 3'b100, "t3_glitch_level");
        push(m + 20, 3'b000, 3'b000, 3'b000, 3'b100, "t3_after_glitch");
        push(m + 24, 3'b000, 3'b000, 3'b100, 3'b100, "t3_hold");
        tick(16); btn[2] = 1'b1;
        push(m + 38, 3'b000, 3'b100, 3'b000, 3'b000, "t3_release");
        tick(20);

        // Reset during a press with the button still held
        tick(1); m = cyc; btn[0] = 1'b0;
        push(m + 8,  3'b001, 3'b000, 3'b000, 3'b001, "t5_press");
        push(m + 10, 3'b000, 3'b000, 3'b000, 3'b001, "t5_level");
        tick(12); nreset = 1'b0;
        push(m + 13, 3'b000, 3'b000, 3'b000, 3'b000, "t5_reset_clears");
        tick(2); nreset = 1'b1;
        push(m + 22, 3'b001, 3'b000, 3'b000, 3'b001, "t5_repress");
        push(m + 38, 3'b000, 3'b000, 3'b001, 3'b001, "t5_hold");
        tick(26); btn[0] = 1'b1;
        push(m + 48, 3'b000, 3'b001, 3'b000, 3'b000, "t5_release");
        tick(20);

        // All three buttons together, staggered releases
        tick(1); m = cyc; btn = 3'b000;
        push(m + 8,  3'b111, 3'b000, 3'b000, 3'b111, "t6_press_all");
        tick(10); btn[1] = 1'b1;
        push(m + 18, 3'b000, 3'b010, 3'b000, 3'b101, "t6_release1");
        push(m + 24, 3'b000, 3'b000, 3'b101, 3'b101, "t6_hold02");
        tick(16); btn[0] = 1'b1;
        push(m + 34, 3'b000, 3'b001, 3'b000, 3'b100, "t6_release0");
        tick(14); btn[2] = 1'b1;
        push(m + 48, 3'b000, 3'b100, 3'b000, 3'b000, "t6_release2");
        tick(20);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter N_BUTTONS, default 3, number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, clock cycles a level must stay stable to be accepted (10 ms at 50 MHz).
REQ-003 Parameter HOLD_CYCLES, default 50000000, clock cycles a press must persist before a hold event (1 s at 50 MHz).
REQ-004 clock  input  1  single system clock, rising-edge active, 20 ns nominal period.
REQ-005 nreset  input  1  asynchronous, active-low reset.
REQ-006 button_n  input  N_BUTTONS  raw board buttons, active-low (0 = pushed), asynchronous to clock.
REQ-007 pressed  output  N_BUTTONS  debounced level, 1 = button held down.
REQ-008 press_pulse  output  N_BUTTONS  one-cycle strobe on accepted press.
REQ-009 release_pulse  output  N_BUTTONS  one-cycle strobe on accepted release.
REQ-010 hold_pulse  output  N_BUTTONS  one-cycle strobe when a press has lasted HOLD_CYCLES.

Function
REQ-011 Each channel SHALL be fully independent; bit i of every output depends only on button_n[i].
REQ-012 Each channel SHALL pass button_n through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL run a 4-state FSM: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-014 IDLE: synchronized input 0 -> DB_PRESS with debounce counter cleared; else stay.
REQ-015 DB_PRESS: input 1 -> IDLE (glitch rejected, no pulse); input 0 for DEBOUNCE_CYCLES consecutive cycles -> PRESSED.
REQ-016 Entry to PRESSED from DB_PRESS SHALL assert press_pulse for exactly one cycle and set pressed=1 in the same cycle.
REQ-017 PRESSED: hold counter increments each cycle; on reaching HOLD_CYCLES, hold_pulse asserts one cycle, then the counter saturates (at most one hold_pulse per press).
REQ-018 PRESSED: synchronized input 1 -> DB_RELEASE with debounce counter cleared.
REQ-019 DB_RELEASE: input 0 -> PRESSED (glitch rejected, pressed stays 1, hold counter retained); input 1 for DEBOUNCE_CYCLES consecutive cycles -> IDLE, asserting release_pulse one cycle and clearing pressed in the same cycle.
REQ-020 The hold counter SHALL continue counting during DB_RELEASE; hold_pulse MAY fire in DB_RELEASE if HOLD_CYCLES is reached there.
REQ-021 Latency: for a clean press, press_pulse SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples button_n low; release latency identical.
REQ-022 press_pulse, release_pulse and hold_pulse SHALL never be high in the same cycle for one channel except hold_pulse coinciding with release_pulse when both conditions mature together.
REQ-023 Counters SHALL be sized to hold their parameter value without wrap; DEBOUNCE_CYCLES>=1, HOLD_CYCLES>DEBOUNCE_CYCLES is required.
REQ-024 All outputs SHALL be registered; no combinational path from button_n to any output.

Reset
REQ-025 nreset low SHALL asynchronously force: synchronizer flops to 1, FSM to IDLE, all counters to 0, all outputs to 0.
REQ-026 Reset asserted mid-press SHALL discard the press; after release of reset with button still held, a fresh press_pulse follows after full debounce latency.
REQ-027 No pulse output SHALL be generated by the reset deassertion itself.

Structure
REQ-028 State enum (IDLE, DB_PRESS, PRESSED, DB_RELEASE) and default timing constants SHALL live in shared package button_pkg.
REQ-029 One sub-module, button_channel (synchronizer + FSM + counters for one button), SHALL be instantiated N_BUTTONS times by a generate loop in button_debounce.

Verification (bench overrides DEBOUNCE_CYCLES=4, HOLD_CYCLES=16)
REQ-030 Clean press of button_n[0] held 30 cycles -> press_pulse[0] one cycle at edge 7 after first low sample, pressed[0]=1, one hold_pulse[0] 16 cycles later, no other channel active.
REQ-031 Bounce: button_n[1] low 2 cycles, high 1, low 10 -> exactly one press_pulse[1], timed from start of final stable low.
REQ-032 Release glitch: while pressed, button_n[2] high 2 cycles then low -> no release_pulse, pressed[2] stays 1.
REQ-033 Clean release after 30-cycle hold -> release_pulse one cycle 7 edges after first high sample, pressed=0.
REQ-034 nreset pulsed low during PRESSED with button still held -> all outputs 0 immediately; new press_pulse 7 edges after reset deasserts.
REQ-035 All three buttons pressed simultaneously -> press_pulse=3'b111 in one cycle, independent hold and release events.
